prog_load_imem: RTL and testbench

//  Parametrised instruction memory for the 8-bit processor. It replaces the fixed 256x16 combinational ROM.

---
 rtl/prog_load_imem.sv | 151 +++++++++++++++
 tb/tb_prog_load_imem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_imem.sv
// Run-time loadable instruction memory: registered fetch with stall hold,
// plus a byte-serial loader that assembles words MSB-first.
module prog_load_imem #(
  parameter int               ADDR_W       = 8,
  parameter int               INSN_W       = 16,
  parameter int               BYTE_W       = 8,
  parameter logic [INSN_W-1:0] NOP_WORD    = '0,
  parameter bit               CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  output logic [INSN_W-1:0] instruction,
  output logic              insn_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_valid,
  input  logic [BYTE_W-1:0] ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);
  localparam int BYTES = INSN_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(BYTES + 1);

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d, cnt_inc;
  logic [INSN_W-1:0]   asm_q, asm_d, asm_shift, wr_data;
  logic [INSN_W-1:0]   instruction_q, instruction_d;
  logic                insn_valid_q, insn_valid_d;
  logic                ld_done_q, ld_done_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [INSN_W-1:0]   mem_q [DEPTH];
  logic                acc, wr_en;
  logic [31:0]         pad_sh;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ld_start)       state_d = S_LOAD;
      S_LOAD:  if (acc && ld_last) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ld_ready = (state_q == S_LOAD);
    ld_busy  = (state_q == S_LOAD);
  end

  assign acc = ld_valid && ld_ready;

  // Loader datapath; a short final word is left-aligned so its tail reads as zero bytes
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_en      = 1'b0;
    ld_done_d  = 1'b0;
    cnt_inc    = byte_cnt_q + CNT_W'(1);
    asm_shift  = (asm_q << BYTE_W) | INSN_W'(ld_byte);
    pad_sh     = 32'((BYTES - int'(cnt_inc)) * BYTE_W);
    wr_data    = asm_shift << pad_sh;
    if (state_q == S_IDLE && ld_start) begin
      wr_ptr_d   = ld_addr;
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (acc) begin
      asm_d      = asm_shift;
      byte_cnt_d = cnt_inc;
      if (cnt_inc == CNT_W'(BYTES) || ld_last) begin
        wr_en      = 1'b1;
        wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
        byte_cnt_d = '0;
        asm_d      = '0;
      end
      ld_done_d = ld_last;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_ptr_q] = 1'b1;
  end

  // Fetch is refused while loading, so reads never see a same-cycle write
  always_comb begin
    instruction_d = instruction_q;
    insn_valid_d  = insn_valid_q;
    if (!stall) begin
      if (fetch_en && state_q == S_IDLE) begin
        instruction_d = valid_q[pc] ? mem_q[pc] : NOP_WORD;
        insn_valid_d  = 1'b1;
      end else begin
        insn_valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      instruction_q <= NOP_WORD;
      insn_valid_q  <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      instruction_q <= instruction_d;
      insn_valid_q  <= insn_valid_d;
      ld_done_q     <= ld_done_d;
    end
  end

  generate
    if (CLEAR_ON_RST) begin : g_valid_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
      end
    end else begin : g_valid_keep
      always_ff @(posedge clk) valid_q <= valid_d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign instruction = instruction_q;
  assign insn_valid  = insn_valid_q;
  assign ld_done     = ld_done_q;
endmodule

// File: tb/tb_prog_load_imem.sv
// Bench for prog_load_imem: directed tables, hand sequences for stall/reset,
// then random loads and fetches against an array-based reference model.
module tb_prog_load_imem;
  logic        clk = 1'b0, rst = 1'b1;
  logic        fetch_en = 1'b0, stall = 1'b0;
  logic [7:0]  pc = '0;
  logic [15:0] instruction;
  logic        insn_valid;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_addr = '0, ld_byte = '0;
  logic        ld_ready, ld_busy, ld_done;

  prog_load_imem dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .stall(stall),
    .instruction(instruction), .insn_valid(insn_valid),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model: word contents, written flags, expected fetch register
  logic [15:0] ref_mem [256];
  bit          ref_valid [256];
  logic [15:0] exp_i = 16'h0000;
  bit          exp_v = 1'b0;

  typedef struct {
    logic [7:0]  addr;
    int          n;
    logic [47:0] bytes;   // MSB-first, left-aligned
  } load_vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] exp;
  } fetch_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    exp_i = 16'h0000;
    exp_v = 1'b0;
  endtask

  task automatic model_load(input logic [7:0] addr, input logic [7:0] b[$]);
    logic [7:0] a;
    for (int i = 0; i < b.size(); i += 2) begin
      a = addr + 8'(i / 2);
      ref_mem[a]   = {b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
      ref_valid[a] = 1'b1;
    end
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] a);
    return ref_valid[a] ? ref_mem[a] : 16'h0000;
  endfunction

  // one IDLE-state fetch cycle, checked against the model
  task automatic fcycle(input bit st, input bit fe, input logic [7:0] p);
    stall = st; fetch_en = fe; pc = p;
    if (!st) begin
      if (fe) begin exp_i = model_read(p); exp_v = 1'b1; end
      else exp_v = 1'b0;
    end
    @(negedge clk);
    chk("fetch_valid", 32'(insn_valid), 32'(exp_v));
    chk("fetch_word", 32'(instruction), 32'(exp_i));
  endtask

  // full load transaction; optionally keeps fetch_en high and inserts idle/ld_start noise
  task automatic do_load(input logic [7:0] addr, input logic [7:0] b[$],
                         input bit fetch_during, input logic [7:0] fpc, input bit noise);
    stall = 1'b0;
    ld_start = 1'b1; ld_addr = addr;
    fetch_en = fetch_during; pc = fpc;
    if (fetch_during) begin exp_i = model_read(fpc); exp_v = 1'b1; end
    else exp_v = 1'b0;
    @(negedge clk);
    chk("ld_busy_start", 32'(ld_busy), 32'd1);
    chk("start_fetch_valid", 32'(insn_valid), 32'(exp_v));
    chk("start_fetch_word", 32'(instruction), 32'(exp_i));
    ld_start = 1'b0;
    exp_v = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        ld_start = 1'b1; ld_addr = 8'($urandom);
        @(negedge clk);
        chk("ld_busy_gap", 32'(ld_busy), 32'd1);
        chk("ld_done_gap", 32'(ld_done), 32'd0);
        ld_start = 1'b0;
      end
      chk("ld_ready", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1; ld_byte = b[i]; ld_last = (i == b.size() - 1);
      @(negedge clk);
      chk("fetch_refused", 32'(insn_valid), 32'd0);
      if (i != b.size() - 1) chk("ld_done_early", 32'(ld_done), 32'd0);
    end
    model_load(addr, b);
    ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
    chk("ld_done_pulse", 32'(ld_done), 32'd1);
    chk("ld_busy_end", 32'(ld_busy), 32'd0);
    chk("held_word", 32'(instruction), 32'(exp_i));
    @(negedge clk);
    chk("ld_done_once", 32'(ld_done), 32'd0);
  endtask

  load_vec_t  lv [3];
  fetch_vec_t fv [8];

  initial begin
    logic [7:0] q[$];
    logic [7:0] ra;
    logic [47:0] bb;

    lv[0] = '{addr: 8'h05, n: 2, bytes: 48'h9104_0000_0000};
    lv[1] = '{addr: 8'hFF, n: 6, bytes: 48'h1122_3344_5566};
    lv[2] = '{addr: 8'h10, n: 1, bytes: 48'hAB00_0000_0000};
    fv[0] = '{pc: 8'h05, exp: 16'h9104};
    fv[1] = '{pc: 8'hFF, exp: 16'h1122};
    fv[2] = '{pc: 8'h00, exp: 16'h3344};
    fv[3] = '{pc: 8'h01, exp: 16'h5566};
    fv[4] = '{pc: 8'h10, exp: 16'hAB00};
    fv[5] = '{pc: 8'h11, exp: 16'h0000};
    fv[6] = '{pc: 8'h06, exp: 16'h0000};
    fv[7] = '{pc: 8'h02, exp: 16'h0000};
    model_clear();

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_instruction", 32'(instruction), 32'h0000);
    chk("rst_insn_valid", 32'(insn_valid), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ld_busy", 32'(ld_busy), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // unwritten word reads as NOP
    fcycle(1'b0, 1'b1, 8'h00);
    chk("t1_nop", 32'(instruction), 32'h0000);
    fcycle(1'b0, 1'b0, 8'h00);

    // table loads, then table fetches
    foreach (lv[k]) begin
      q.delete();
      bb = lv[k].bytes;
      for (int i = 0; i < lv[k].n; i++) q.push_back(bb[47-8*i -: 8]);
      do_load(lv[k].addr, q, 1'b0, 8'h00, 1'b0);
    end
    foreach (fv[k]) begin
      fcycle(1'b0, 1'b1, fv[k].pc);
      chk("tbl_fetch", 32'(instruction), 32'(fv[k].exp));
    end

    // stall holds across pc change and fetch_en
    fcycle(1'b0, 1'b1, 8'h05);
    for (int i = 0; i < 3; i++) begin
      fcycle(1'b1, 1'b1, 8'h00);
      chk("stall_word", 32'(instruction), 32'h9104);
      chk("stall_valid", 32'(insn_valid), 32'd1);
    end
    fcycle(1'b1, 1'b0, 8'h00);
    fcycle(1'b0, 1'b0, 8'h00);
    chk("unstall_drop", 32'(insn_valid), 32'd0);

    // same-cycle ld_start + fetch served from pre-load contents; fetch refused in LOAD
    q.delete(); q.push_back(8'hDE); q.push_back(8'hAD);
    do_load(8'h05, q, 1'b1, 8'h05, 1'b0);
    chk("preload_word", 32'(instruction), 32'h9104);
    fcycle(1'b0, 1'b1, 8'h05);
    chk("overwrite", 32'(instruction), 32'hDEAD);

    // reset during LOAD discards partial word and suppresses ld_done
    ld_start = 1'b1; ld_addr = 8'h20;
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b1; ld_byte = 8'h12; ld_last = 1'b0;
    @(negedge clk);
    ld_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(ld_busy), 32'd0);
    chk("midrst_ready", 32'(ld_ready), 32'd0);
    chk("midrst_done", 32'(ld_done), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_done_after", 32'(ld_done), 32'd0);
    fcycle(1'b0, 1'b1, 8'h20);
    chk("midrst_fetch20", 32'(instruction), 32'h0000);
    fcycle(1'b0, 1'b1, 8'h05);
    chk("midrst_cleared05", 32'(instruction), 32'h0000);

    // random loads interleaved with random fetch/stall traffic
    for (int t = 0; t < 25; t++) begin
      q.delete();
      ra = 8'($urandom);
      if (t % 5 == 0) ra = 8'hFD;
      for (int i = 0; i < $urandom_range(1, 9); i++) q.push_back(8'($urandom));
      do_load(ra, q, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      for (int c = 0; c < 30; c++)
        fcycle(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 1) == 1) ? ra + 8'($urandom_range(0, 4)) : 8'($urandom));
    end
    stall = 1'b0; fetch_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
